// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_pkg
// Description : Shared encodings for the iterative divider. Holds the FSM
//               state codes, the result-ready levels and the start/stop
//               request levels.
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

    // FSM state encodings (2 bits)
    localparam logic [1:0] c_DIV_IDLE = 2'd0;
    localparam logic [1:0] c_DIV_ZERO = 2'd1;
    localparam logic [1:0] c_DIV_ON   = 2'd2;
    localparam logic [1:0] c_DIV_END  = 2'd3;

    // Result-valid levels
    localparam logic c_DIV_RESULT_READY     = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY = 1'b0;

    // Start request levels driven by EX
    localparam logic c_DIV_START = 1'b1;
    localparam logic c_DIV_STOP  = 1'b0;

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration (combinational).
//               Shifts the next dividend bit into the partial remainder,
//               trial-subtracts the divisor and keeps the difference when it
//               is non-negative.
// Ports       : i_rem          - partial remainder (always < divisor)
//               i_divisor      - divisor magnitude
//               i_dividend_bit - next dividend bit, MSB first
//               o_rem          - updated partial remainder
//               o_quo_bit      - quotient bit produced by this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_dividend_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_quo_bit
);

    // One extra bit so the shifted remainder never overflows.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {i_rem, i_dividend_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    // MSB of the difference is the borrow: set means the trial went negative.
    // When negative, the shifted value is below the divisor, so its top bit
    // is zero and dropping it is lossless.
    assign o_quo_bit = ~w_diff[WIDTH];
    assign o_rem     = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Multi-cycle restoring divider for the EX stage. Performs
//               signed (DIV) or unsigned (DIVU) division one quotient bit per
//               cycle, with divide-by-zero short cut, annul for flushed
//               instructions and a busy flag for stall generation.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               start_i    - divide request, held until ready_o is seen
//               annul_i    - cancel current/requested divide (priority)
//               signed_i   - 1 = signed, 0 = unsigned (sampled with start)
//               opdata1_i  - dividend (sampled with start)
//               opdata2_i  - divisor  (sampled with start)
//               result_o   - {remainder, quotient} (HI:LO)
//               ready_o    - result valid
//               busy_o     - unit not idle
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    import div_iter_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    // Dividend shifts out of the top while quotient bits shift into the
    // bottom; after WIDTH iterations this register holds the quotient.
    logic [WIDTH-1:0] r_dvd_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_quo;
    logic             r_neg_rem;

    logic             w_start_req;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_quo_bit;
    logic [WIDTH-1:0] w_quo_raw;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_start_req = (start_i == c_DIV_START) && !annul_i;

    // Operand magnitudes; only negative signed operands are negated.
    assign w_dvd_neg = signed_i & opdata1_i[WIDTH-1];
    assign w_dvs_neg = signed_i & opdata2_i[WIDTH-1];
    assign w_abs_dvd = w_dvd_neg ? -opdata1_i : opdata1_i;
    assign w_abs_dvs = w_dvs_neg ? -opdata2_i : opdata2_i;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem          (r_rem),
        .i_divisor      (r_dvs),
        .i_dividend_bit (r_dvd_quo[WIDTH-1]),
        .o_rem          (w_step_rem),
        .o_quo_bit      (w_quo_bit)
    );

    // Final-iteration values with sign fix-up applied. MIN / -1 falls out
    // naturally: |MIN| is MIN as an unsigned value and negating it wraps
    // back to MIN.
    assign w_quo_raw = {r_dvd_quo[WIDTH-2:0], w_quo_bit};
    assign w_quo_fix = r_neg_quo ? -w_quo_raw  : w_quo_raw;
    assign w_rem_fix = r_neg_rem ? -w_step_rem : w_step_rem;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_DIV_IDLE: begin
                if (w_start_req) begin
                    w_next_state = (opdata2_i == '0) ? c_DIV_ZERO : c_DIV_ON;
                end
            end
            c_DIV_ZERO: begin
                w_next_state = annul_i ? c_DIV_IDLE : c_DIV_END;
            end
            c_DIV_ON: begin
                if (annul_i) begin
                    w_next_state = c_DIV_IDLE;
                end else if (r_cnt == c_LAST_ITER) begin
                    w_next_state = c_DIV_END;
                end
            end
            c_DIV_END: begin
                if (annul_i || (start_i == c_DIV_STOP)) begin
                    w_next_state = c_DIV_IDLE;
                end
            end
            default: w_next_state = c_DIV_IDLE;
        endcase
    end

    // State register and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_DIV_IDLE;
            ready_o <= c_DIV_RESULT_NOT_READY;
            busy_o  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            ready_o <= (w_next_state == c_DIV_END) ? c_DIV_RESULT_READY
                                                    : c_DIV_RESULT_NOT_READY;
            busy_o  <= (w_next_state != c_DIV_IDLE);
        end
    end

    // Datapath: operand capture, iteration and result update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd_quo <= '0;
            r_dvs     <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            result_o  <= '0;
        end else begin
            case (r_state)
                c_DIV_IDLE: begin
                    if (w_start_req && (opdata2_i != '0)) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_dvd_quo <= w_abs_dvd;
                        r_dvs     <= w_abs_dvs;
                        r_neg_quo <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_rem <= w_dvd_neg;
                    end
                end
                c_DIV_ZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                    end
                end
                c_DIV_ON: begin
                    if (!annul_i) begin
                        r_rem     <= w_step_rem;
                        r_dvd_quo <= w_quo_raw;
                        r_cnt     <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_LAST_ITER) begin
                            result_o <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Directed self-checking bench for div_iter with a 32-bit and
//               an 8-bit instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk;
    logic        rst;

    logic        start32, annul32, signed32;
    logic [31:0] op1_32, op2_32;
    logic [63:0] res32;
    logic        ready32, busy32;

    logic        start8, annul8, signed8;
    logic [7:0]  op1_8, op2_8;
    logic [15:0] res8;
    logic        ready8, busy8;

    int total = 0;
    int bad   = 0;

    div_iter #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start32),
        .annul_i   (annul32),
        .signed_i  (signed32),
        .opdata1_i (op1_32),
        .opdata2_i (op2_32),
        .result_o  (res32),
        .ready_o   (ready32),
        .busy_o    (busy32)
    );

    div_iter #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start8),
        .annul_i   (annul8),
        .signed_i  (signed8),
        .opdata1_i (op1_8),
        .opdata2_i (op2_8),
        .result_o  (res8),
        .ready_o   (ready8),
        .busy_o    (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full 32-bit operation: latency, result, hold in END, return to IDLE.
    task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        signed32 = sgn; op1_32 = a; op2_32 = b; annul32 = 1'b0; start32 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                op1_32 = $urandom;
                op2_32 = $urandom;
                signed32 = ~sgn;
            end
        end while (!ready32 && n < 100);
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, res32, exp_res);
        chk({tag, " busy"}, 64'(busy32), 64'd1);
        @(posedge clk); #1;
        chk({tag, " hold ready"}, 64'(ready32), 64'd1);
        chk({tag, " hold result"}, res32, exp_res);
        start32 = 1'b0;
        @(posedge clk); #1;
        chk({tag, " idle ready"}, 64'(ready32), 64'd0);
        chk({tag, " idle busy"}, 64'(busy32), 64'd0);
        chk({tag, " idle result"}, res32, exp_res);
    endtask

    task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        signed8 = sgn; op1_8 = a; op2_8 = b; annul8 = 1'b0; start8 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                op1_8 = 8'($urandom);
                op2_8 = 8'($urandom);
            end
        end while (!ready8 && n < 100);
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, 64'(res8), 64'(exp_res));
        start8 = 1'b0;
        @(posedge clk); #1;
        chk({tag, " idle busy"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        logic seen_ready;
        rst = 1'b1;
        start32 = 1'b0; annul32 = 1'b0; signed32 = 1'b0; op1_32 = '0; op2_32 = '0;
        start8  = 1'b0; annul8  = 1'b0; signed8  = 1'b0; op1_8  = '0; op2_8  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result32", res32, 64'd0);
        chk("reset ready32", 64'(ready32), 64'd0);
        chk("reset busy32", 64'(busy32), 64'd0);
        chk("reset result8", 64'(res8), 64'd0);
        rst = 1'b0;

        run32("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run32("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run32("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run32("u/0", 1'b0, 32'd12345, 32'd0, 64'd0, 2);
        run32("s-7/2b", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run32("s/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 64'd0, 2);
        run32("u100/7b", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Annul part-way through the iterations.
        @(negedge clk);
        signed32 = 1'b0; op1_32 = 32'd100; op2_32 = 32'd7; start32 = 1'b1;
        seen_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen_ready = seen_ready | ready32;
        end
        annul32 = 1'b1;
        @(posedge clk); #1;
        seen_ready = seen_ready | ready32;
        chk("annul ready seen", 64'(seen_ready), 64'd0);
        chk("annul busy", 64'(busy32), 64'd0);
        chk("annul result kept", res32, {32'd2, 32'd14});
        run32("u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        run32("sMIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run32("uFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);

        run8("w8 255/16", 1'b0, 8'd255, 8'd16, {8'd15, 8'd15}, 9);
        run8("w8 s-100/7", 1'b1, 8'h9C, 8'd7, {8'hFE, 8'hF2}, 9);
        run8("w8 255/16b", 1'b0, 8'd255, 8'd16, {8'd15, 8'd15}, 9);

        // Reset while iterating.
        @(negedge clk);
        signed8 = 1'b0; op1_8 = 8'd200; op2_8 = 8'd3; start8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("w8 busy before rst", 64'(busy8), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("w8 rst result", 64'(res8), 64'd0);
        chk("w8 rst ready", 64'(ready8), 64'd0);
        chk("w8 rst busy", 64'(busy8), 64'd0);
        rst = 1'b0;
        start8 = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle restoring divider for the EX stage of the 5-stage MIPS core.
- Replaces the divide state held in EX and fed back through EX/MEM (div_stat / tmp_rem / tmp_quo / shift_cnt) with a self-contained unit.
- Generalises that state to any operand width and adds per-operation signed/unsigned mode, an annul input for flushed instructions, and a busy flag for the ctrl stall logic.
- EX drives start_i and holds the operands; it raises a stall request while busy_o is high and start_i is asserted.

Parameters:
- WIDTH, 32, operand width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  request a divide; must stay high until ready_o is seen.
- annul_i  in  1  cancel the current or requested divide (pipeline flush).
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- result_o  out  2*WIDTH  {remainder, quotient}, i.e. HI:LO.
- ready_o  out  1  result valid.
- busy_o  out  1  high in any non-IDLE state.

Behaviour:
- All outputs are registered. On reset: state = IDLE, result_o = 0, ready_o = 0, busy_o = 0. Reset mid-operation aborts at the next edge.
- IDLE:
  - start_i=1, annul_i=0, divisor=0 -> DIVZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. Latch |dividend| and |divisor| (absolute values only when signed_i=1), latch the sign flags, and clear count.
  - Otherwise stay in IDLE with ready_o=0.
- DIVZERO: takes one cycle, then -> END with result_o = 0.
- ON: one iteration per cycle.
  - Form the trial subtraction (partial_rem<<1 | next dividend bit) - divisor.
  - Non-negative: take the difference and shift in a quotient bit of 1.
  - Negative: keep the shifted value and shift in 0.
  - Increment count. When count reaches WIDTH, go to END in the same cycle the last iteration completes.
- Sign fix-up on entry to END, when signed_i was latched:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Two's-complement wrap: MIN / -1 gives quotient = MIN, remainder = 0.
- END: ready_o=1 and result_o is valid and held stable. Stay in END while start_i=1. start_i=0 -> IDLE with ready_o=0 on the next edge; result_o keeps its last value.
- annul_i=1 in ON, DIVZERO or END -> IDLE on the next edge; ready_o=0; result_o unchanged. annul_i has priority over start_i.
- Latency from the start edge to ready_o:
  - Divisor nonzero: WIDTH+1 edges (1 load + WIDTH iterations; ready_o is visible after edge WIDTH+1).
  - Divisor zero: 2 edges.
- No new start is accepted until the unit has returned to IDLE (a minimum of one cycle with start_i=0).
- Operand changes after acceptance are ignored.

Decomposition:
- Shared package/defines.vh holds:
  - state encodings DivIdle/DivZero/DivOn/DivEnd (2 bits);
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop.
- Sub-module div_step: combinational, WIDTH-parametrised trial subtract/shift for one iteration. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder, quotient bit.
- The FSM, counter and sign fix-up stay in div_iter.

Test Plan:
- Unsigned 100/7, WIDTH=32: start held -> ready_o rises 33 edges after start; result_o = {32'd2, 32'd14}; drop start -> IDLE after 1 edge, busy_o=0.
- Signed -7/2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (any dividend, either mode): ready_o after 2 edges; result_o = 0.
- Annul: start 100/7, assert annul_i at iteration 10 -> IDLE next edge, ready_o never asserts. Immediately start 9/3 -> {0, 3} with full latency.
- Corner: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- WIDTH=8 instance: unsigned 255/16 -> {8'd15, 8'd15}, ready after 9 edges. Assert rst mid-ON -> all outputs 0 next edge.
